// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: signals between memory_map, the transmit FIFO and the uart.
// The "slave" modport is the FIFO. The "master" modport is its environment:
// the memory_map write path and the uart.
// Build option: UART_TX_FIFO_OVERFLOW_EN adds the overflow / overflow_clr pair.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    // Write side (memory_map)
    logic [7:0]         wr_data;
    logic               wr_req;
    logic               full;
    logic               empty;
    logic [LEVEL_W-1:0] level;

    // Transmit side (uart)
    logic [7:0]         tx_data;
    logic               tx_req;
    logic               tx_busy;

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic               overflow;
    logic               overflow_clr;

    modport slave (
        input  wr_data, wr_req, tx_busy, overflow_clr,
        output full, empty, level, tx_data, tx_req, overflow
    );

    modport master (
        output wr_data, wr_req, tx_busy, overflow_clr,
        input  full, empty, level, tx_data, tx_req, overflow
    );
`else
    modport slave (
        input  wr_data, wr_req, tx_busy,
        output full, empty, level, tx_data, tx_req
    );

    modport master (
        output wr_data, wr_req, tx_busy,
        input  full, empty, level, tx_data, tx_req
    );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus transmit sequencer between memory_map's uart
// write path and the uart transmitter. It absorbs single-cycle byte writes and
// hands bytes to the uart one frame at a time with one-cycle tx_req pulses.
// Build option: UART_TX_FIFO_OVERFLOW_EN adds a sticky overflow flag for
// writes dropped while full. The flag is cleared by overflow_clr.
module uart_tx_fifo #(
    parameter int  DEPTH   = 16,
    localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_next;
    logic               full_q;
    logic               empty_q;
    logic [7:0]         tx_data_q;
    logic               tx_req_q;
    logic [1:0]         wait_cnt;
    logic               wr_accept;
    logic               pop;

    // A write is judged against the registered full flag. A pop in the same
    // cycle frees a slot only on the following cycle.
    assign wr_accept = bus.wr_req && !full_q;
    assign pop       = (state == IDLE) && !empty_q && !bus.tx_busy;

    // Next fill count: a write and a pop in the same cycle cancel out.
    always_comb begin
        // NOTE: default first so every path assigns level_next and no latch is inferred.
        level_next = level_q;
        unique case ({wr_accept, pop})
            2'b10:   level_next = level_q + LEVEL_W'(1);
            2'b01:   level_next = level_q - LEVEL_W'(1);
            default: level_next = level_q;
        endcase
    end

    // Byte storage. Only accepted writes land here.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset. Zeroed pointers and level make stale bytes unreachable.
        if (wr_accept) begin
            mem[wptr] <= bus.wr_data;
        end
    end

    // Write pointer advances once per accepted byte and wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            wptr <= '0;
        end else if (wr_accept) begin
            wptr <= wptr + PTR_W'(1);
        end
    end

    // Registered fill status. All three flags update together, one cycle after the cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            level_q <= level_next;
            full_q  <= (level_next == LEVEL_W'(DEPTH));
            empty_q <= (level_next == '0);
        end
    end

    // Transmit sequencer. It pops one byte per uart frame and gives up waiting
    // for tx_busy after four quiet cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx_req_q  <= 1'b0;
            tx_data_q <= 8'h00;
            rptr      <= '0;
            wait_cnt  <= '0;
        end else begin
            tx_req_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data_q <= mem[rptr];
                        rptr      <= rptr + PTR_W'(1);
                        tx_req_q  <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == 2'd3) begin
                        // The uart ignored the request. The byte is treated as sent.
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic overflow_q;

    // Sticky drop flag. Setting it wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (bus.wr_req && full_q) begin
            overflow_q <= 1'b1;
        end else if (bus.overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.overflow = overflow_q;
`endif

    assign bus.level   = level_q;
    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_req  = tx_req_q;

endmodule
